// File: rtl/savestate_ctrl.sv
// rtl/savestate_ctrl.sv - savestate request sequencer with one pending slot, engine handshake and OSD info codes
// Optional feature: define SS_LOAD_EMPTY_CHECK_EN to answer loads of empty slots with code 31 without touching the engine.
module savestate_ctrl #(
  parameter int TIMEOUT_BITS = 24,
  parameter int SLOT_SHIFT   = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ss_save,
  input  logic        ss_load,
  input  logic [1:0]  ss_slot,
  output logic        engine_start_save,
  output logic        engine_start_load,
  output logic [31:0] engine_addr,
  input  logic        engine_done,
  input  logic        engine_error,
  output logic        busy,
  output logic        info_req,
  output logic [7:0]  info,
  output logic [3:0]  slot_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam logic [7:0] CODE_OK_BASE  = 8'd20;
  localparam logic [7:0] CODE_ERR_BASE = 8'd28;
  localparam logic [7:0] CODE_TIMEOUT  = 8'd30;
  localparam logic [7:0] CODE_EMPTY    = 8'd31;

  state_t state_q, state_d;

  // op encoding: 0 = save, 1 = load
  logic                    op_q;
  logic [1:0]              slot_q;
  logic [31:0]             addr_q;
  logic [7:0]              info_q, info_d;
  logic [3:0]              valid_q, valid_d;
  logic [TIMEOUT_BITS-1:0] wdog_q;

  logic       pend_valid_q;
  logic       pend_op_q;
  logic [1:0] pend_slot_q;

  logic       live_req;
  logic       live_op;
  logic       accept;
  logic       acc_op;
  logic [1:0] acc_slot;
  logic       take_pend;
  logic       store_live;

  assign live_req = ss_save | ss_load;
  assign live_op  = ~ss_save;

  // A live strobe is consumed directly only when the FSM is idle with nothing queued.
  assign store_live = live_req & ~((state_q == S_IDLE) & ~pend_valid_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    take_pend = 1'b0;
    acc_op    = live_op;
    acc_slot  = ss_slot;
    info_d    = info_q;
    valid_d   = valid_q;

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          accept    = 1'b1;
          take_pend = 1'b1;
          acc_op    = pend_op_q;
          acc_slot  = pend_slot_q;
        end else if (live_req) begin
          accept = 1'b1;
        end

        if (accept) begin
`ifdef SS_LOAD_EMPTY_CHECK_EN
          if (acc_op && !valid_q[acc_slot]) begin
            state_d = S_REPORT;
            info_d  = CODE_EMPTY;
          end else begin
            state_d = S_START;
          end
`else
          state_d = S_START;
`endif
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (engine_done) begin
          state_d = S_REPORT;
          if (!engine_error) begin
            info_d = CODE_OK_BASE + 8'({slot_q, op_q});
            if (!op_q) valid_d[slot_q] = 1'b1;
          end else begin
            info_d = CODE_ERR_BASE + 8'(op_q);
            if (!op_q) valid_d[slot_q] = 1'b0;
          end
        end else if (wdog_q[TIMEOUT_BITS-1]) begin
          state_d = S_REPORT;
          info_d  = CODE_TIMEOUT;
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= 1'b0;
      slot_q       <= 2'd0;
      addr_q       <= 32'd0;
      info_q       <= 8'd0;
      valid_q      <= 4'd0;
      wdog_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= 1'b0;
      pend_slot_q  <= 2'd0;
    end else begin
      if (accept) begin
        op_q   <= acc_op;
        slot_q <= acc_slot;
        addr_q <= 32'(acc_slot) << SLOT_SHIFT;
      end

      if (state_q == S_START) begin
        wdog_q <= '0;
      end else if (state_q == S_WAIT) begin
        wdog_q <= wdog_q + TIMEOUT_BITS'(1);
      end

      info_q  <= info_d;
      valid_q <= valid_d;

      // Last request wins: a newer strobe overwrites whatever is queued.
      if (store_live) begin
        pend_valid_q <= 1'b1;
        pend_op_q    <= live_op;
        pend_slot_q  <= ss_slot;
      end else if (take_pend) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign engine_start_save = (state_q == S_START) & ~op_q;
  assign engine_start_load = (state_q == S_START) & op_q;
  assign engine_addr       = addr_q;
  assign busy              = (state_q != S_IDLE);
  assign info_req          = (state_q == S_REPORT);
  assign info              = info_q;
  assign slot_valid        = valid_q;

endmodule
